// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control path:
//   - instruction register field positions (opcode, Ra, Rb, Rc)
//   - opcode constants
//   - control sequencer state enumeration
//   - opcode classification helper used to pick the T3..T7 micro-sequence
// ----------------------------------------------------------------------------
package cpu_pkg;

  // Instruction register layout
  localparam int IR_W    = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam int OPC_W   = 5;
  localparam int REG_N   = 16;

  // Opcodes
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_MFHI = 5'b10011;
  localparam logic [OPC_W-1:0] OPC_MFLO = 5'b10100;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9
  } state_e;

  // Instruction families sharing a micro-sequence
  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,  // NOP and every undefined opcode
    CLS_RTYPE  = 4'd1,
    CLS_MULDIV = 4'd2,
    CLS_ADDI   = 4'd3,
    CLS_LD     = 4'd4,
    CLS_ST     = 4'd5,
    CLS_MFHI   = 4'd6,
    CLS_MFLO   = 4'd7,
    CLS_HALT   = 4'd8
  } op_class_e;

  function automatic op_class_e classify(input logic [OPC_W-1:0] opc);
    op_class_e cls;
    cls = CLS_NONE;
    if ((opc >= OPC_ADD) && (opc <= OPC_SHL)) begin
      cls = CLS_RTYPE;
    end else begin
      case (opc)
        OPC_MUL,
        OPC_DIV:  cls = CLS_MULDIV;
        OPC_ADDI: cls = CLS_ADDI;
        OPC_LD:   cls = CLS_LD;
        OPC_ST:   cls = CLS_ST;
        OPC_MFHI: cls = CLS_MFHI;
        OPC_MFLO: cls = CLS_MFLO;
        OPC_HALT: cls = CLS_HALT;
        default:  cls = CLS_NONE;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/reg_decode_4_16.sv
// ----------------------------------------------------------------------------
// reg_decode_4_16
// 4-to-16 one-hot decoder for a register-select field of the instruction.
// Ports:
//   i_sel    [3:0]  register number (0..15); 0 still selects R0
//   i_en            output is all-zero when low
//   o_onehot [15:0] one-hot select, bit n = Rn
// ----------------------------------------------------------------------------
module reg_decode_4_16
  import cpu_pkg::*;
(
  input  logic [3:0]       i_sel,
  input  logic             i_en,
  output logic [REG_N-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Moore control unit for a bus-based CPU datapath. Walks a fetch sequence
// (T0..T2) and then an opcode-dependent execute sequence (T3..T7), driving
// register load enables, bus source selects, ALU op and memory strobes.
// Ports:
//   clk            clock, rising edge
//   clr            asynchronous active-low reset (state -> IDLE, outputs 0)
//   ir [31:0]      instruction register (opcode/Ra/Rb/Rc), used from T3 on
//   mem_done       memory transfer complete (honoured in T1, LD T6, ST T7)
//   reg_in [15:0]  one-hot register load enables R0in..R15in
//   reg_out [15:0] one-hot register bus drives R0out..R15out
//   enable_*       datapath register load enables
//   select_*       bus source selects
//   pc_inc         PC loads incremented value
//   Read [1:0]     MDR source: 01 memory, 00 bus
//   Write          memory write strobe
//   OP [4:0]       ALU operation
//   run            high while executing (T0..T7)
// ----------------------------------------------------------------------------
module control_sequencer
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [IR_W-1:0]  ir,
  input  logic             mem_done,
  output logic [REG_N-1:0] reg_in,
  output logic [REG_N-1:0] reg_out,
  output logic             enable_PC,
  output logic             enable_IR,
  output logic             enable_HI,
  output logic             enable_LO,
  output logic             enable_ZHI,
  output logic             enable_ZLO,
  output logic             enable_MAR,
  output logic             enable_MDR,
  output logic             enable_Y,
  output logic             enable_C,
  output logic             select_PC,
  output logic             select_HI,
  output logic             select_LO,
  output logic             select_ZHI,
  output logic             select_ZLO,
  output logic             select_MDR,
  output logic             select_C,
  output logic             pc_inc,
  output logic [1:0]       Read,
  output logic             Write,
  output logic [OPC_W-1:0] OP,
  output logic             run
);

  state_e           r_state;
  state_e           w_next_state;

  logic [OPC_W-1:0] w_opcode;
  op_class_e        w_cls;

  // Which decoded field drives reg_in / reg_out this cycle
  logic             w_ra_in;
  logic             w_ra_out;
  logic             w_rb_out;
  logic             w_rc_out;

  logic [REG_N-1:0] w_ra_oh;
  logic [REG_N-1:0] w_rb_oh;
  logic [REG_N-1:0] w_rc_oh;

  logic             w_unused_ir_bits;

  assign w_opcode         = ir[OPC_MSB:OPC_LSB];
  assign w_cls            = classify(w_opcode);
  assign w_unused_ir_bits = ^ir[RC_LSB-1:0];

  reg_decode_4_16 u_dec_ra (
    .i_sel    (ir[RA_MSB:RA_LSB]),
    .i_en     (w_ra_in | w_ra_out),
    .o_onehot (w_ra_oh)
  );

  reg_decode_4_16 u_dec_rb (
    .i_sel    (ir[RB_MSB:RB_LSB]),
    .i_en     (w_rb_out),
    .o_onehot (w_rb_oh)
  );

  reg_decode_4_16 u_dec_rc (
    .i_sel    (ir[RC_MSB:RC_LSB]),
    .i_en     (w_rc_out),
    .o_onehot (w_rc_oh)
  );

  // At most one field is flagged per state, so the priority mux never
  // merges two one-hot vectors.
  assign reg_in  = w_ra_in  ? w_ra_oh : '0;
  assign reg_out = w_ra_out ? w_ra_oh :
                   w_rb_out ? w_rb_oh :
                   w_rc_out ? w_rc_oh : '0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ra_in      = 1'b0;
    w_ra_out     = 1'b0;
    w_rb_out     = 1'b0;
    w_rc_out     = 1'b0;
    enable_PC    = 1'b0;
    enable_IR    = 1'b0;
    enable_HI    = 1'b0;
    enable_LO    = 1'b0;
    enable_ZHI   = 1'b0;
    enable_ZLO   = 1'b0;
    enable_MAR   = 1'b0;
    enable_MDR   = 1'b0;
    enable_Y     = 1'b0;
    enable_C     = 1'b0;
    select_PC    = 1'b0;
    select_HI    = 1'b0;
    select_LO    = 1'b0;
    select_ZHI   = 1'b0;
    select_ZLO   = 1'b0;
    select_MDR   = 1'b0;
    select_C     = 1'b0;
    pc_inc       = 1'b0;
    Read         = 2'b00;
    Write        = 1'b0;
    OP           = '0;
    run          = (r_state != S_IDLE) && (r_state != S_HALTED);

    case (r_state)
      S_IDLE: begin
        w_next_state = S_T0;
      end

      S_T0: begin
        select_PC    = 1'b1;
        enable_MAR   = 1'b1;
        pc_inc       = 1'b1;
        w_next_state = S_T1;
      end

      S_T1: begin
        Read         = 2'b01;
        enable_MDR   = 1'b1;
        w_next_state = mem_done ? S_T2 : S_T1;
      end

      S_T2: begin
        select_MDR   = 1'b1;
        enable_IR    = 1'b1;
        w_next_state = S_T3;
      end

      // First execute step: ir is trusted from here on
      S_T3: begin
        case (w_cls)
          CLS_RTYPE, CLS_ADDI, CLS_LD, CLS_ST: begin
            w_rb_out     = 1'b1;
            enable_Y     = 1'b1;
            w_next_state = S_T4;
          end
          CLS_MULDIV: begin
            w_ra_out     = 1'b1;
            enable_Y     = 1'b1;
            w_next_state = S_T4;
          end
          CLS_MFHI: begin
            select_HI    = 1'b1;
            w_ra_in      = 1'b1;
            w_next_state = S_T0;
          end
          CLS_MFLO: begin
            select_LO    = 1'b1;
            w_ra_in      = 1'b1;
            w_next_state = S_T0;
          end
          CLS_HALT: w_next_state = S_HALTED;
          default:  w_next_state = S_T0;
        endcase
      end

      S_T4: begin
        w_next_state = S_T5;
        case (w_cls)
          CLS_RTYPE: begin
            w_rc_out   = 1'b1;
            OP         = w_opcode;
            enable_ZLO = 1'b1;
          end
          CLS_MULDIV: begin
            w_rb_out   = 1'b1;
            OP         = w_opcode;
            enable_ZHI = 1'b1;
            enable_ZLO = 1'b1;
          end
          // Address / immediate add: Y + C through the ALU adder
          CLS_ADDI, CLS_LD, CLS_ST: begin
            select_C   = 1'b1;
            OP         = OPC_ADD;
            enable_ZLO = 1'b1;
          end
          default: w_next_state = S_T0;
        endcase
      end

      S_T5: begin
        w_next_state = S_T0;
        case (w_cls)
          CLS_RTYPE, CLS_ADDI: begin
            select_ZLO = 1'b1;
            w_ra_in    = 1'b1;
          end
          CLS_MULDIV: begin
            select_ZLO   = 1'b1;
            enable_LO    = 1'b1;
            w_next_state = S_T6;
          end
          CLS_LD, CLS_ST: begin
            select_ZLO   = 1'b1;
            enable_MAR   = 1'b1;
            w_next_state = S_T6;
          end
          default: w_next_state = S_T0;
        endcase
      end

      S_T6: begin
        w_next_state = S_T0;
        case (w_cls)
          CLS_MULDIV: begin
            select_ZHI = 1'b1;
            enable_HI  = 1'b1;
          end
          CLS_LD: begin
            Read         = 2'b01;
            enable_MDR   = 1'b1;
            w_next_state = mem_done ? S_T7 : S_T6;
          end
          // Store data goes bus -> MDR (Read stays 00)
          CLS_ST: begin
            w_ra_out     = 1'b1;
            enable_MDR   = 1'b1;
            w_next_state = S_T7;
          end
          default: w_next_state = S_T0;
        endcase
      end

      S_T7: begin
        w_next_state = S_T0;
        case (w_cls)
          CLS_LD: begin
            select_MDR = 1'b1;
            w_ra_in    = 1'b1;
          end
          CLS_ST: begin
            Write        = 1'b1;
            w_next_state = mem_done ? S_T0 : S_T7;
          end
          default: w_next_state = S_T0;
        endcase
      end

      // Only clr leaves HALTED
      S_HALTED: w_next_state = S_HALTED;

      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench for control_sequencer. All outputs are packed into one
// observation vector and compared against hand-built expected vectors each
// cycle, one task per scenario.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic        mem_done;
  logic [15:0] reg_in;
  logic [15:0] reg_out;
  logic        enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI;
  logic        enable_ZLO, enable_MAR, enable_MDR, enable_Y, enable_C;
  logic        select_PC, select_HI, select_LO, select_ZHI, select_ZLO;
  logic        select_MDR, select_C;
  logic        pc_inc;
  logic [1:0]  Read;
  logic        Write;
  logic [4:0]  OP;
  logic        run;

  int n_checks;
  int n_fail;

  control_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .ir         (ir),
    .mem_done   (mem_done),
    .reg_in     (reg_in),
    .reg_out    (reg_out),
    .enable_PC  (enable_PC),
    .enable_IR  (enable_IR),
    .enable_HI  (enable_HI),
    .enable_LO  (enable_LO),
    .enable_ZHI (enable_ZHI),
    .enable_ZLO (enable_ZLO),
    .enable_MAR (enable_MAR),
    .enable_MDR (enable_MDR),
    .enable_Y   (enable_Y),
    .enable_C   (enable_C),
    .select_PC  (select_PC),
    .select_HI  (select_HI),
    .select_LO  (select_LO),
    .select_ZHI (select_ZHI),
    .select_ZLO (select_ZLO),
    .select_MDR (select_MDR),
    .select_C   (select_C),
    .pc_inc     (pc_inc),
    .Read       (Read),
    .Write      (Write),
    .OP         (OP),
    .run        (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vector: {reg_in, reg_out, en[9:0], sel[6:0], pc_inc, Read, Write, OP, run}
  logic [58:0] obs;
  assign obs = {reg_in, reg_out,
                enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI,
                enable_ZLO, enable_MAR, enable_MDR, enable_Y, enable_C,
                select_PC, select_HI, select_LO, select_ZHI, select_ZLO,
                select_MDR, select_C,
                pc_inc, Read, Write, OP, run};

  localparam logic [9:0] E_PC  = 10'h200, E_IR  = 10'h100, E_HI  = 10'h080;
  localparam logic [9:0] E_LO  = 10'h040, E_ZHI = 10'h020, E_ZLO = 10'h010;
  localparam logic [9:0] E_MAR = 10'h008, E_MDR = 10'h004, E_Y   = 10'h002;
  localparam logic [6:0] S_PC  = 7'h40, S_HI  = 7'h20, S_LO = 7'h10;
  localparam logic [6:0] S_ZHI = 7'h08, S_ZLO = 7'h04, S_MDR = 7'h02, S_C = 7'h01;

  function automatic logic [58:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic [9:0] en, input logic [6:0] sel,
                                     input logic pci, input logic [1:0] rd,
                                     input logic wr, input logic [4:0] op,
                                     input logic rn);
    return {rin, rout, en, sel, pci, rd, wr, op, rn};
  endfunction

  logic [58:0] X_ZERO, X_T0, X_T1, X_T2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr      = 1'b1;
    mem_done = 1'b1;
    ir       = 32'h1891_8000;
    #2 clr = 1'b0;
    tick();
    tick();
    n_checks++;
    if (obs !== X_ZERO) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, X_ZERO);
    end
    mem_done = 1'b0;
    tick();
    n_checks++;
    if (obs !== X_ZERO) begin
      n_fail++;
      $display("FAIL reset_hold_md0: got %h expected %h", obs, X_ZERO);
    end
    clr = 1'b1;
    #1;
    n_checks++;
    if (obs !== X_ZERO) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h expected %h", obs, X_ZERO);
    end
  endtask

  // ADD R1,R2,R3 straight out of reset
  task automatic test_add();
    logic [58:0] xv [7];
    mem_done = 1'b1;
    ir       = 32'h1891_8000;
    xv[0] = X_T0;
    xv[1] = X_T1;
    xv[2] = X_T2;
    xv[3] = mk('0, 16'h0004, E_Y, '0, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[4] = mk('0, 16'h0008, E_ZLO, '0, 1'b0, 2'b00, 1'b0, 5'b00011, 1'b1);
    xv[5] = mk(16'h0002, '0, '0, S_ZLO, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[6] = X_T0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (obs !== xv[i]) begin
        n_fail++;
        $display("FAIL add step %0d: got %h expected %h", i, obs, xv[i]);
      end
    end
  endtask

  // MUL R4,R5 with a 4-cycle T1; ir garbage during early fetch
  task automatic test_mul();
    logic [58:0] xv [10];
    logic        mv [10];
    mv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    xv[0] = X_T1;
    xv[1] = X_T1;
    xv[2] = X_T1;
    xv[3] = X_T1;
    xv[4] = X_T2;
    xv[5] = mk('0, 16'h0010, E_Y, '0, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[6] = mk('0, 16'h0020, E_ZHI | E_ZLO, '0, 1'b0, 2'b00, 1'b0, 5'b01111, 1'b1);
    xv[7] = mk('0, '0, E_LO, S_ZLO, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[8] = mk('0, '0, E_HI, S_ZHI, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[9] = X_T0;
    ir = 32'hD800_0000;
    for (int i = 0; i < 10; i++) begin
      mem_done = mv[i];
      if (i == 4) ir = {5'b01111, 4'd4, 4'd5, 4'd0, 15'd0};
      tick();
      n_checks++;
      if (obs !== xv[i]) begin
        n_fail++;
        $display("FAIL mul step %0d: got %h expected %h", i, obs, xv[i]);
      end
    end
  endtask

  // LD R6,(R2) with T6 waiting two cycles
  task automatic test_ld();
    logic [58:0] xv [10];
    logic        mv [10];
    mv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ir = {5'b00000, 4'd6, 4'd2, 4'd0, 15'd0};
    xv[0] = X_T1;
    xv[1] = X_T2;
    xv[2] = mk('0, 16'h0004, E_Y, '0, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[3] = mk('0, '0, E_ZLO, S_C, 1'b0, 2'b00, 1'b0, 5'b00011, 1'b1);
    xv[4] = mk('0, '0, E_MAR, S_ZLO, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[5] = mk('0, '0, E_MDR, '0, 1'b0, 2'b01, 1'b0, 5'b00000, 1'b1);
    xv[6] = xv[5];
    xv[7] = xv[5];
    xv[8] = mk(16'h0040, '0, '0, S_MDR, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[9] = X_T0;
    for (int i = 0; i < 10; i++) begin
      mem_done = mv[i];
      tick();
      n_checks++;
      if (obs !== xv[i]) begin
        n_fail++;
        $display("FAIL ld step %0d: got %h expected %h", i, obs, xv[i]);
      end
    end
  endtask

  // ST R7,(R3) with Write held until mem_done
  task automatic test_st();
    logic [58:0] xv [10];
    logic        mv [10];
    mv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ir = {5'b00001, 4'd7, 4'd3, 4'd0, 15'd0};
    xv[0] = X_T1;
    xv[1] = X_T2;
    xv[2] = mk('0, 16'h0008, E_Y, '0, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[3] = mk('0, '0, E_ZLO, S_C, 1'b0, 2'b00, 1'b0, 5'b00011, 1'b1);
    xv[4] = mk('0, '0, E_MAR, S_ZLO, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[5] = mk('0, 16'h0080, E_MDR, '0, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[6] = mk('0, '0, '0, '0, 1'b0, 2'b00, 1'b1, 5'b00000, 1'b1);
    xv[7] = xv[6];
    xv[8] = xv[6];
    xv[9] = X_T0;
    for (int i = 0; i < 10; i++) begin
      mem_done = mv[i];
      tick();
      n_checks++;
      if (obs !== xv[i]) begin
        n_fail++;
        $display("FAIL st step %0d: got %h expected %h", i, obs, xv[i]);
      end
    end
  endtask

  // MFHI R9
  task automatic test_mfhi();
    logic [58:0] xv [4];
    mem_done = 1'b1;
    ir = {5'b10011, 4'd9, 4'd0, 4'd0, 15'd0};
    xv[0] = X_T1;
    xv[1] = X_T2;
    xv[2] = mk(16'h0200, '0, '0, S_HI, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[3] = X_T0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs !== xv[i]) begin
        n_fail++;
        $display("FAIL mfhi step %0d: got %h expected %h", i, obs, xv[i]);
      end
    end
  endtask

  // Undefined opcode 11111: T3 drives nothing, back to T0
  task automatic test_undefined();
    logic [58:0] xv [4];
    mem_done = 1'b1;
    ir = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
    xv[0] = X_T1;
    xv[1] = X_T2;
    xv[2] = mk('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    xv[3] = X_T0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs !== xv[i]) begin
        n_fail++;
        $display("FAIL undef step %0d: got %h expected %h", i, obs, xv[i]);
      end
    end
  endtask

  // HALT, then 20 cycles parked in HALTED with mem_done wiggling
  task automatic test_halt();
    logic [58:0] xv [3];
    mem_done = 1'b1;
    ir = {5'b11011, 12'd0, 15'd0};
    xv[0] = X_T1;
    xv[1] = X_T2;
    xv[2] = mk('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== xv[i]) begin
        n_fail++;
        $display("FAIL halt step %0d: got %h expected %h", i, obs, xv[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      mem_done = (i % 3) != 0;
      n_checks++;
      if (obs !== X_ZERO) begin
        n_fail++;
        $display("FAIL halted cycle %0d: got %h expected %h", i, obs, X_ZERO);
      end
    end
  endtask

  // Leave HALTED by reset, run ST up to T7, then pulse clr mid-T7
  task automatic test_clr_during_st();
    logic [58:0] x_wr;
    x_wr = mk('0, '0, '0, '0, 1'b0, 2'b00, 1'b1, 5'b00000, 1'b1);
    clr = 1'b0;
    #1;
    n_checks++;
    if (obs !== X_ZERO) begin
      n_fail++;
      $display("FAIL clr_from_halt: got %h expected %h", obs, X_ZERO);
    end
    clr = 1'b1;
    tick();
    n_checks++;
    if (obs !== X_T0) begin
      n_fail++;
      $display("FAIL clr_from_halt_t0: got %h expected %h", obs, X_T0);
    end
    ir = {5'b00001, 4'd7, 4'd1, 4'd0, 15'd0};
    for (int i = 0; i < 7; i++) begin
      mem_done = (i < 2);
      tick();
    end
    mem_done = 1'b0;
    n_checks++;
    if (obs !== x_wr) begin
      n_fail++;
      $display("FAIL clr_st_t7_write: got %h expected %h", obs, x_wr);
    end
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if (obs !== X_ZERO) begin
      n_fail++;
      $display("FAIL clr_st_async: got %h expected %h", obs, X_ZERO);
    end
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if (obs !== X_ZERO) begin
      n_fail++;
      $display("FAIL clr_st_idle: got %h expected %h", obs, X_ZERO);
    end
    tick();
    n_checks++;
    if (obs !== X_T0) begin
      n_fail++;
      $display("FAIL clr_st_t0: got %h expected %h", obs, X_T0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b1;
    mem_done = 1'b0;
    ir       = '0;
    X_ZERO = '0;
    X_T0   = mk('0, '0, E_MAR, S_PC, 1'b1, 2'b00, 1'b0, 5'b00000, 1'b1);
    X_T1   = mk('0, '0, E_MDR, '0, 1'b0, 2'b01, 1'b0, 5'b00000, 1'b1);
    X_T2   = mk('0, '0, E_IR, S_MDR, 1'b0, 2'b00, 1'b0, 5'b00000, 1'b1);

    test_reset();
    test_add();
    test_mul();
    test_ld();
    test_st();
    test_mfhi();
    test_undefined();
    test_halt();
    test_clr_during_st();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Ports SHALL be as follows:
- clk, input, 1: sole clock; all state updates occur on the rising edge.
- clr, input, 1: reset; asynchronous, active-low.
- ir, input, 32: current instruction register value. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- mem_done, input, 1: memory transfer complete, sampled on the rising edge.
- reg_in, output, 16: one-hot register load enables, R0in..R15in.
- reg_out, output, 16: one-hot register bus drives, R0out..R15out.
- enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI, enable_ZLO, enable_MAR, enable_MDR, enable_Y, enable_C: output, 1 each; register load enables.
- select_PC, select_HI, select_LO, select_ZHI, select_ZLO, select_MDR, select_C: output, 1 each; bus source selects.
- pc_inc, output, 1: PC loads the incremented value.
- Read, output, 2: MDR source; 2'b01 = memory data, 2'b00 = bus.
- Write, output, 1: memory write strobe.
- OP, output, 5: ALU operation code.
- run, output, 1: high while executing; low in reset, IDLE and HALTED.

Function
REQ-002 Outputs SHALL be Moore-decoded from the state register plus ir fields; every output not listed for a state SHALL be 0.
REQ-003 States SHALL be IDLE, T0..T7 and HALTED. IDLE SHALL go to T0 unconditionally.
REQ-004 Fetch:
- T0: select_PC, enable_MAR, pc_inc.
- T1: Read=01, enable_MDR; hold in T1 until mem_done=1.
- T2: select_MDR, enable_IR.
- Then go to T3.
REQ-005 R-type (opcodes 00011-01000: ADD, SUB, AND, OR, SHR, SHL):
- T3: reg_out[Rb], enable_Y.
- T4: reg_out[Rc], OP=opcode, enable_ZLO.
- T5: select_ZLO, reg_in[Ra].
- Then go to T0.
REQ-006 MUL (01111) / DIV (10000):
- T3: reg_out[Ra], enable_Y.
- T4: reg_out[Rb], OP=opcode, enable_ZHI, enable_ZLO.
- T5: select_ZLO, enable_LO.
- T6: select_ZHI, enable_HI.
- Then go to T0.
REQ-007 ADDI (01001):
- T3: reg_out[Rb], enable_Y.
- T4: select_C, OP=00011, enable_ZLO.
- T5: select_ZLO, reg_in[Ra].
- Then go to T0.
REQ-008 LD (00000) and ST (00001) SHALL share T3-T4 with ADDI, then:
- T5: select_ZLO, enable_MAR.
- LD T6: Read=01, enable_MDR; hold until mem_done.
- LD T7: select_MDR, reg_in[Ra].
- ST T6: reg_out[Ra], Read=00, enable_MDR.
- ST T7: Write=1; hold until mem_done.
- Both then go to T0.
REQ-009 MFHI (10011) / MFLO (10100) SHALL, in T3, assert select_HI / select_LO with reg_in[Ra], then go to T0.
REQ-010 NOP (11010) and every undefined opcode SHALL go from T3 directly to T0 with all outputs 0.
REQ-011 HALT (11011) SHALL go from T3 to HALTED. HALTED SHALL be left only by reset, with all outputs 0 and run=0.
REQ-012 reg_in and reg_out SHALL each have at most one bit set in any cycle. Ra=0 SHALL still select R0.
REQ-013 mem_done asserted outside T1, LD T6 or ST T7 SHALL be ignored.
REQ-014 ir SHALL be sampled only from T3 onward; ir changes during T0-T2 SHALL not alter the fetch sequence.

Reset
REQ-015 clr=0 SHALL force the state to IDLE asynchronously and all outputs to 0, including run, regardless of state (including mid-wait in T1, LD T6 or ST T7).
REQ-016 After clr is released, the first rising edge SHALL move IDLE to T0.

Structure
REQ-017 Opcode constants, the state enumeration and the ir field positions SHALL reside in shared package cpu_pkg.
REQ-018 The Ra/Rb/Rc 4-to-16 one-hot decode SHALL be a single sub-module, reg_decode_4_16, instantiated once per decoded field.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release, mem_done tied 1, ir=ADD R1,R2,R3 (0x18918000) -> T0,T1,T2,T3,T4,T5 in 6 cycles; reg_out=0x0004 in T3, 0x0008 with OP=00011 in T4, reg_in=0x0002 in T5.
- MUL R4,R5 with mem_done held 0 for 3 cycles in T1 -> T1 held for exactly 4 cycles; enable_LO in T5 and enable_HI in T6.
- LD R6 with mem_done low 2 cycles in T6 -> Read=01 held for 3 cycles; T7 asserts select_MDR and reg_in=0x0040.
- ST R7 -> T6 asserts reg_out=0x0080 with Read=00; Write held until mem_done=1, then T0.
- Opcode 11111 -> T3 then T0 with no enables; HALT -> run=0, held for 20 cycles under any mem_done.
- clr pulsed low during ST T7 -> Write drops to 0 within the same cycle; after release, IDLE then T0.
